// File: rtl/peripheral_bus_arbiter.sv
// Two-master round-robin arbiter for the shared register-block peripheral bus.
// A grant is held until the slave completes the access or the busy timeout aborts it.
module peripheral_bus_arbiter #(
    parameter int unsigned ADDRESS_WIDTH  = 12,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     m0_we,
    input  logic                     m0_oe,
    input  logic [ADDRESS_WIDTH-1:0] m0_address,
    input  logic [3:0]               m0_byteSelect,
    input  logic [31:0]              m0_dataWrite,
    output logic [31:0]              m0_dataRead,
    output logic                     m0_busy,
    output logic                     m0_error,
    input  logic                     m1_we,
    input  logic                     m1_oe,
    input  logic [ADDRESS_WIDTH-1:0] m1_address,
    input  logic [3:0]               m1_byteSelect,
    input  logic [31:0]              m1_dataWrite,
    output logic [31:0]              m1_dataRead,
    output logic                     m1_busy,
    output logic                     m1_error,
    output logic                     peripheralBus_we,
    output logic                     peripheralBus_oe,
    output logic [ADDRESS_WIDTH-1:0] peripheralBus_address,
    output logic [3:0]               peripheralBus_byteSelect,
    output logic [31:0]              peripheralBus_dataWrite,
    input  logic [31:0]              peripheralBus_dataRead,
    input  logic                     peripheralBus_busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_last_grant;
    logic               w_next_last_grant;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_next_count;

    logic                     w_req0;
    logic                     w_req1;
    logic                     w_sel;
    logic                     w_sel_req;
    logic                     w_other_req;
    logic                     w_sel_we;
    logic                     w_sel_oe;
    logic [ADDRESS_WIDTH-1:0] w_sel_address;
    logic [3:0]               w_sel_byteSelect;
    logic [31:0]              w_sel_dataWrite;
    logic                     w_sel_busy;
    logic [31:0]              w_sel_dataRead;
    logic                     w_sel_error;

    assign w_req0 = m0_we | m0_oe;
    assign w_req1 = m1_we | m1_oe;

    // w_sel is the index of the granted master; only meaningful in GRANT0/GRANT1
    assign w_sel            = (r_state == GRANT1);
    assign w_sel_req        = w_sel ? w_req1        : w_req0;
    assign w_other_req      = w_sel ? w_req0        : w_req1;
    assign w_sel_we         = w_sel ? m1_we         : m0_we;
    assign w_sel_oe         = w_sel ? m1_oe         : m0_oe;
    assign w_sel_address    = w_sel ? m1_address    : m0_address;
    assign w_sel_byteSelect = w_sel ? m1_byteSelect : m0_byteSelect;
    assign w_sel_dataWrite  = w_sel ? m1_dataWrite  : m0_dataWrite;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_count      <= '0;
        end else begin
            r_state      <= w_next_state;
            r_last_grant <= w_next_last_grant;
            r_count      <= w_next_count;
        end
    end

    always_comb begin
        w_next_state             = r_state;
        w_next_last_grant        = r_last_grant;
        w_next_count             = r_count;
        peripheralBus_we         = 1'b0;
        peripheralBus_oe         = 1'b0;
        peripheralBus_address    = '0;
        peripheralBus_byteSelect = '0;
        peripheralBus_dataWrite  = '0;
        m0_dataRead              = '0;
        m1_dataRead              = '0;
        m0_busy                  = w_req0;
        m1_busy                  = w_req1;
        m0_error                 = 1'b0;
        m1_error                 = 1'b0;
        w_sel_busy               = 1'b0;
        w_sel_dataRead           = '0;
        w_sel_error              = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_req0 && w_req1) begin
                    w_next_state = r_last_grant ? GRANT0 : GRANT1;
                end else if (w_req0) begin
                    w_next_state = GRANT0;
                end else if (w_req1) begin
                    w_next_state = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                peripheralBus_we         = w_sel_we;
                peripheralBus_oe         = w_sel_oe;
                peripheralBus_address    = w_sel_address;
                peripheralBus_byteSelect = w_sel_byteSelect;
                peripheralBus_dataWrite  = w_sel_dataWrite;
                w_sel_dataRead           = peripheralBus_dataRead;
                w_sel_busy               = w_sel_req;

                if (!w_sel_req) begin
                    w_next_state = IDLE;
                    w_next_count = '0;
                end else if (!peripheralBus_busy ||
                             (r_count == CNT_W'(TIMEOUT_CYCLES - 1))) begin
                    // Completion and timeout abort share the same handoff path
                    w_sel_busy = 1'b0;
                    if (peripheralBus_busy) begin
                        w_sel_dataRead = 32'hFFFF_FFFF;
                        w_sel_error    = 1'b1;
                    end
                    w_next_last_grant = w_sel;
                    w_next_count      = '0;
                    if (w_other_req) begin
                        w_next_state = w_sel ? GRANT0 : GRANT1;
                    end else begin
                        w_next_state = IDLE;
                    end
                end else begin
                    w_next_count = r_count + CNT_W'(1);
                end

                if (w_sel) begin
                    m1_busy     = w_sel_busy;
                    m1_dataRead = w_sel_dataRead;
                    m1_error    = w_sel_error;
                end else begin
                    m0_busy     = w_sel_busy;
                    m0_dataRead = w_sel_dataRead;
                    m0_error    = w_sel_error;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_count = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_peripheral_bus_arbiter.sv
// Directed bench for peripheral_bus_arbiter: stimulus pushes expected completions,
// a negedge monitor pops and compares them whenever a master's access finishes.
module tb_peripheral_bus_arbiter;

    localparam int unsigned AW = 12;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_we, m0_oe, m1_we, m1_oe;
    logic [AW-1:0] m0_address, m1_address;
    logic [3:0]    m0_byteSelect, m1_byteSelect;
    logic [31:0]   m0_dataWrite, m1_dataWrite;
    logic [31:0]   m0_dataRead, m1_dataRead;
    logic          m0_busy, m1_busy, m0_error, m1_error;
    logic          peripheralBus_we, peripheralBus_oe;
    logic [AW-1:0] peripheralBus_address;
    logic [3:0]    peripheralBus_byteSelect;
    logic [31:0]   peripheralBus_dataWrite;
    logic [31:0]   slv_data;
    logic          slv_busy;

    typedef struct packed {
        logic          m;
        logic [31:0]   data;
        logic          err;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    peripheral_bus_arbiter #(.ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .m0_we                    (m0_we),
        .m0_oe                    (m0_oe),
        .m0_address               (m0_address),
        .m0_byteSelect            (m0_byteSelect),
        .m0_dataWrite             (m0_dataWrite),
        .m0_dataRead              (m0_dataRead),
        .m0_busy                  (m0_busy),
        .m0_error                 (m0_error),
        .m1_we                    (m1_we),
        .m1_oe                    (m1_oe),
        .m1_address               (m1_address),
        .m1_byteSelect            (m1_byteSelect),
        .m1_dataWrite             (m1_dataWrite),
        .m1_dataRead              (m1_dataRead),
        .m1_busy                  (m1_busy),
        .m1_error                 (m1_error),
        .peripheralBus_we         (peripheralBus_we),
        .peripheralBus_oe         (peripheralBus_oe),
        .peripheralBus_address    (peripheralBus_address),
        .peripheralBus_byteSelect (peripheralBus_byteSelect),
        .peripheralBus_dataWrite  (peripheralBus_dataWrite),
        .peripheralBus_dataRead   (slv_data),
        .peripheralBus_busy       (slv_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic m, input logic [31:0] data, input logic err,
                            input logic [AW-1:0] addr);
        exp_t e;
        e.m    = m;
        e.data = data;
        e.err  = err;
        e.addr = addr;
        exp_q.push_back(e);
    endtask

    task automatic mon(input logic m, input logic req, input logic busy,
                       input logic [31:0] data, input logic err);
        exp_t e;
        if (req && !busy) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_completion: master %0d addr 0x%0h", m, peripheralBus_address);
            end else begin
                e = exp_q.pop_front();
                chk("completion_master", 64'(m), 64'(e.m));
                chk("completion_data", 64'(data), 64'(e.data));
                chk("completion_error", 64'(err), 64'(e.err));
                chk("completion_addr", 64'(peripheralBus_address), 64'(e.addr));
            end
        end else if (err) begin
            tests_run++;
            tests_failed++;
            $display("FAIL stray_error: master %0d error=1 without completion", m);
        end
    endtask

    // Monitor: any cycle where a requesting master sees busy low is a finished access
    always @(negedge clk) begin
        if (!rst) begin
            mon(1'b0, m0_we | m0_oe, m0_busy, m0_dataRead, m0_error);
            mon(1'b1, m1_we | m1_oe, m1_busy, m1_dataRead, m1_error);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m0_we = 1'b0; m0_oe = 1'b0; m0_address = '0; m0_byteSelect = '0; m0_dataWrite = '0;
        m1_we = 1'b0; m1_oe = 1'b0; m1_address = '0; m1_byteSelect = '0; m1_dataWrite = '0;
        slv_busy = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          hi;
        logic [1:0]  bt [7];
        logic        b4 [5];

        slv_data = 32'hCAFE_F00D;
        do_reset();

        // Reset state
        @(negedge clk);
        chk("reset_bus", 64'({peripheralBus_we, peripheralBus_oe, peripheralBus_address,
                              peripheralBus_byteSelect, peripheralBus_dataWrite}), 64'h0);
        chk("reset_m0_dataRead", 64'(m0_dataRead), 64'h0);
        chk("reset_m1_dataRead", 64'(m1_dataRead), 64'h0);
        chk("reset_busy_err", 64'({m0_busy, m1_busy, m0_error, m1_error}), 64'h0);
        step();

        // Single read
        m0_oe = 1'b1; m0_address = 12'h010; slv_data = 32'h1234_5678;
        push_exp(1'b0, 32'h1234_5678, 1'b0, 12'h010);
        @(negedge clk);
        chk("t1_c0_m0_busy", 64'(m0_busy), 64'h1);
        chk("t1_c0_bus_oe", 64'(peripheralBus_oe), 64'h0);
        step();
        @(negedge clk);
        chk("t1_c1_bus", 64'({peripheralBus_oe, peripheralBus_address}), 64'({1'b1, 12'h010}));
        chk("t1_c1_dataRead", 64'(m0_dataRead), 64'h1234_5678);
        chk("t1_c1_m0_busy", 64'(m0_busy), 64'h0);
        step();
        m0_oe = 1'b0;
        @(negedge clk);
        chk("t1_c2_idle_bus_oe", 64'(peripheralBus_oe), 64'h0);
        step();

        // Simultaneous requests after reset: m0 first, then m1 with no idle bubble
        do_reset();
        m0_we = 1'b1; m0_address = 12'h020; m0_dataWrite = 32'hDEAD_BEEF; m0_byteSelect = 4'hF;
        m1_oe = 1'b1; m1_address = 12'h030; slv_data = 32'h0000_A5A5;
        push_exp(1'b0, 32'h0000_A5A5, 1'b0, 12'h020);
        push_exp(1'b1, 32'h0000_A5A5, 1'b0, 12'h030);
        hi = 0;
        @(negedge clk);
        if (m1_busy) hi++;
        chk("t2_c0_bus_we", 64'(peripheralBus_we), 64'h0);
        step();
        @(negedge clk);
        if (m1_busy) hi++;
        chk("t2_c1_bus_write", 64'({peripheralBus_we, peripheralBus_byteSelect, peripheralBus_dataWrite}),
            64'({1'b1, 4'hF, 32'hDEAD_BEEF}));
        step();
        m0_we = 1'b0;
        @(negedge clk);
        chk("t2_c2_grant1", 64'({peripheralBus_we, peripheralBus_oe, peripheralBus_address}),
            64'({1'b0, 1'b1, 12'h030}));
        chk("t2_c2_m1_busy", 64'(m1_busy), 64'h0);
        step();
        m1_oe = 1'b0;
        chk("t2_m1_busy_cycles", 64'(hi), 64'd2);

        // Fairness: both request continuously, order 0,1,0,1,0,1
        m0_oe = 1'b1; m0_address = 12'h040;
        m1_oe = 1'b1; m1_address = 12'h050;
        for (int i = 0; i < 3; i++) begin
            push_exp(1'b0, 32'h0000_A5A5, 1'b0, 12'h040);
            push_exp(1'b1, 32'h0000_A5A5, 1'b0, 12'h050);
        end
        bt[0] = 2'b11; bt[1] = 2'b01; bt[2] = 2'b10; bt[3] = 2'b01;
        bt[4] = 2'b10; bt[5] = 2'b01; bt[6] = 2'b00;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk($sformatf("t3_c%0d_busy", i), 64'({m0_busy, m1_busy}), 64'(bt[i]));
            step();
            if (i == 5) m0_oe = 1'b0;
            if (i == 6) m1_oe = 1'b0;
        end

        // Slave stall: three busy cycles then completion on the 4th granted cycle
        m1_we = 1'b1; m1_address = 12'h060; m1_dataWrite = 32'h1122_3344; m1_byteSelect = 4'h3;
        slv_busy = 1'b1; slv_data = 32'h0BAD_F00D;
        push_exp(1'b1, 32'h0BAD_F00D, 1'b0, 12'h060);
        b4[0] = 1'b1; b4[1] = 1'b1; b4[2] = 1'b1; b4[3] = 1'b1; b4[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) slv_busy = 1'b0;
            @(negedge clk);
            chk($sformatf("t4_c%0d_m1_busy", i), 64'(m1_busy), 64'(b4[i]));
            chk($sformatf("t4_c%0d_m1_error", i), 64'(m1_error), 64'h0);
            if (i == 1)
                chk("t4_c1_bus_write", 64'({peripheralBus_we, peripheralBus_byteSelect, peripheralBus_dataWrite}),
                    64'({1'b1, 4'h3, 32'h1122_3344}));
            step();
        end
        m1_we = 1'b0;

        // Timeout on m0 read with m1 pending: abort on 4th granted cycle, then GRANT1
        m0_oe = 1'b1; m0_address = 12'h070;
        m1_oe = 1'b1; m1_address = 12'h080;
        slv_busy = 1'b1; slv_data = 32'h5A5A_5A5A;
        push_exp(1'b0, 32'hFFFF_FFFF, 1'b1, 12'h070);
        push_exp(1'b1, 32'h5A5A_5A5A, 1'b0, 12'h080);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) slv_busy = 1'b0;
            @(negedge clk);
            if (i >= 1 && i <= 3) chk($sformatf("t5_c%0d_m0_busy", i), 64'(m0_busy), 64'h1);
            if (i == 4) begin
                chk("t5_c4_m0_error", 64'(m0_error), 64'h1);
                chk("t5_c4_m0_dataRead", 64'(m0_dataRead), 64'hFFFF_FFFF);
                chk("t5_c4_m0_busy", 64'(m0_busy), 64'h0);
                chk("t5_c4_bus_held", 64'({peripheralBus_oe, peripheralBus_address}), 64'({1'b1, 12'h070}));
            end
            if (i == 5) begin
                chk("t5_c5_m0_error", 64'(m0_error), 64'h0);
                chk("t5_c5_grant1", 64'({peripheralBus_oe, peripheralBus_address}), 64'({1'b1, 12'h080}));
                chk("t5_c5_m1_busy", 64'(m1_busy), 64'h0);
            end
            step();
            if (i == 4) m0_oe = 1'b0;
            if (i == 5) m1_oe = 1'b0;
        end

        // Reset during a stalled GRANT1
        m1_oe = 1'b1; m1_address = 12'h090; slv_busy = 1'b1; slv_data = 32'h7777_0001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 2)
                chk("t6_c2_grant1_stall", 64'({peripheralBus_oe, peripheralBus_address, m1_busy}),
                    64'({1'b1, 12'h090, 1'b1}));
            step();
        end
        rst = 1'b1;
        @(negedge clk);
        step();
        rst = 1'b0;
        m0_we = 1'b1; m0_address = 12'h0A0; m0_dataWrite = 32'h0; m0_byteSelect = 4'h0;
        @(negedge clk);
        chk("t6_post_reset_bus", 64'({peripheralBus_we, peripheralBus_oe, peripheralBus_address,
                                      peripheralBus_byteSelect, peripheralBus_dataWrite}), 64'h0);
        chk("t6_post_reset_err", 64'({m0_error, m1_error}), 64'h0);
        chk("t6_post_reset_m1_dataRead", 64'(m1_dataRead), 64'h0);
        push_exp(1'b0, 32'h7777_0001, 1'b0, 12'h0A0);
        push_exp(1'b1, 32'h7777_0001, 1'b0, 12'h090);
        step();
        slv_busy = 1'b0;
        @(negedge clk);
        chk("t6_tie_to_m0", 64'({peripheralBus_we, peripheralBus_address}), 64'({1'b1, 12'h0A0}));
        step();
        m0_we = 1'b0;
        @(negedge clk);
        chk("t6_then_m1", 64'({peripheralBus_oe, peripheralBus_address}), 64'({1'b1, 12'h090}));
        step();
        m1_oe = 1'b0;
        step();
        step();
        chk("queue_drained", 64'(exp_q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/peripheral_bus_arbiter.md
Name: peripheral_bus_arbiter

Overview:
- Shares one peripheral bus, which feeds the register blocks, between two requesters.
- m0 is the external management/Wishbone bridge; m1 is the on-chip core's peripheral port.
- Round-robin grant; the grant is held until the granted transaction completes (slave busy low) or times out.
- A timed-out access is aborted: the requester gets a bus-error pulse and read data 0xFFFFFFFF.

Parameters:
- ADDRESS_WIDTH, 12, peripheral bus address width.
- TIMEOUT_CYCLES, 255, maximum consecutive busy cycles per granted access before abort; must be ≥1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- m0_we  input  1  master 0 write request (level, held until m0_busy low)
- m0_oe  input  1  master 0 read request (level)
- m0_address  input  ADDRESS_WIDTH  master 0 address
- m0_byteSelect  input  4  master 0 byte enables
- m0_dataWrite  input  32  master 0 write data
- m0_dataRead  output  32  master 0 read data
- m0_busy  output  1  master 0 stall; transaction completes in the cycle m0_busy is low while requesting
- m0_error  output  1  one-cycle pulse: master 0 access timed out
- m1_we / m1_oe / m1_address / m1_byteSelect / m1_dataWrite / m1_dataRead / m1_busy / m1_error  same as m0, for master 1
- peripheralBus_we  output  1  to register blocks
- peripheralBus_oe  output  1  to register blocks
- peripheralBus_address  output  ADDRESS_WIDTH  to register blocks
- peripheralBus_byteSelect  output  4  to register blocks
- peripheralBus_dataWrite  output  32  to register blocks
- peripheralBus_dataRead  input  32  OR of register block read data
- peripheralBus_busy  input  1  OR of register block busy

Behaviour:
- Request: mN_req = mN_we | mN_oe. A request with both we and oe high is still arbitrated and forwarded unchanged; register blocks ignore it.
- States: IDLE, GRANT0, GRANT1 (registered). lastGrant register, 1 bit.
- Reset: state IDLE, lastGrant=1 (m0 wins first tie), timeout counter 0, all bus outputs 0, mN_error 0, mN_dataRead 0. mN_busy equals mN_req while in IDLE.
- IDLE:
  - If only mN_req is high, go to GRANTN.
  - If both are high, grant the master not equal to lastGrant.
  - Bus outputs stay 0 in IDLE, so arbitration costs exactly 1 cycle of latency.
- GRANTN:
  - peripheralBus_* carry mN's inputs combinationally.
  - mN_dataRead = peripheralBus_dataRead.
  - Other master: dataRead 0, busy = its req.
- Completion: in GRANTN with mN_req high and peripheralBus_busy low.
  - mN_busy low that cycle; lastGrant<=N; counter<=0.
  - Next state: GRANTother if the other req is high (back-to-back handoff, no IDLE bubble), else IDLE.
- Stall: in GRANTN with peripheralBus_busy high, mN_busy high and counter increments.
- Timeout: counter==TIMEOUT_CYCLES-1 while peripheralBus_busy is still high. In that cycle:
  - mN_busy low, mN_dataRead=32'hFFFFFFFF, mN_error=1 (combinational single-cycle pulse).
  - lastGrant, counter and next state updated exactly as on completion.
  - Bus outputs remain driven that cycle and drop on the next.
- Request withdrawn in GRANTN (mN_req low): go to IDLE next cycle, counter<=0, lastGrant unchanged, no error. Bus outputs follow mN's (now-inactive) inputs that cycle.
- mN_busy when not granted: equals mN_req; there is no busy without a request.
- Reset mid-transaction: next cycle is IDLE with all outputs 0. The slave sees we/oe drop. No error pulse.
- Counter width: clog2(TIMEOUT_CYCLES+1). It never wraps.

Test Plan:
- Single read: m0_oe=1, address 0x010, slave busy=0, dataRead=0x12345678 -> cycle 0 m0_busy=1; cycle 1 bus oe=1, address 0x010, m0_dataRead=0x12345678, m0_busy=0; cycle 2 IDLE.
- Simultaneous after reset: m0_we and m1_oe both held -> GRANT0 first. m0 completes; next cycle GRANT1 with no IDLE. m1 completes; m1_busy is high for exactly 2 cycles before its completion cycle.
- Fairness: both request continuously for 6 transactions -> grant order 0,1,0,1,0,1. Each master's busy low exactly once per own grant.
- Slave stall: m1_we, peripheralBus_busy high for 3 cycles then low -> m1_busy low only on the 4th granted cycle; m1_error never set.
- Timeout with TIMEOUT_CYCLES=4: peripheralBus_busy stuck high on an m0 read -> on the 4th granted cycle m0_busy=0, m0_dataRead=0xFFFFFFFF, m0_error=1 for 1 cycle. Next cycle: IDLE, or GRANT1 if m1 is pending.
- Reset mid-stall: rst=1 during GRANT1 with busy high -> next cycle all peripheralBus outputs 0, state IDLE. The first grant after reset goes to m0 on a tie.
